// File: rtl/elc3_soc_jtag_scan_master.sv
// rtl/elc3_soc_jtag_scan_master.sv - virtual-JTAG scan master: UIR, CDR, DR_WIDTH x SDR, UDR per command
// TCK is divided from clk; one "step" is a full low+high TCK period.
module elc3_soc_jtag_scan_master #(
  parameter int TCK_DIV  = 2,
  parameter int DR_WIDTH = 38
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [1:0]          ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int            CW       = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [7:0]    DIV_LAST = 8'(TCK_DIV - 1);
  localparam logic [CW-1:0] CNT_TOP  = CW'(DR_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_div;
  logic                r_tck;
  logic [CW-1:0]       r_cnt;
  logic [DR_WIDTH-1:0] r_sr;
  logic                r_tdo_hold;
  logic [1:0]          r_ir;
  logic [DR_WIDTH-1:0] r_rsp_data;
  logic                r_rsp_valid;

  logic w_busy;
  logic w_accept;
  logic w_half_end;
  logic w_tck_rise;
  logic w_step_end;

  assign w_busy     = (r_state != S_IDLE);
  assign w_accept   = cmd_valid & ~w_busy;
  assign w_half_end = w_busy & (r_div == DIV_LAST);
  assign w_tck_rise = w_half_end & ~r_tck;
  assign w_step_end = w_half_end & r_tck;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid)  w_state_nxt = S_UIR;
      S_UIR:   if (w_step_end) w_state_nxt = S_CDR;
      S_CDR:   if (w_step_end) w_state_nxt = S_SDR;
      S_SDR:   if (w_step_end && (r_cnt == '0)) w_state_nxt = S_UDR;
      S_UDR:   if (w_step_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready      = 1'b0;
    jtag_state_rti = 1'b0;
    vs_uir         = 1'b0;
    vs_cdr         = 1'b0;
    vs_sdr         = 1'b0;
    vs_udr         = 1'b0;
    tdi            = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready      = 1'b1;
        jtag_state_rti = 1'b1;
      end
      S_UIR: vs_uir = 1'b1;
      S_CDR: vs_cdr = 1'b1;
      S_SDR: begin
        vs_sdr = 1'b1;
        tdi    = r_sr[0];
      end
      S_UDR: vs_udr = 1'b1;
      default: ;
    endcase
  end

  // tdo is captured as tck rises, then shifted in at the following step end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div       <= '0;
      r_tck       <= 1'b0;
      r_cnt       <= '0;
      r_sr        <= '0;
      r_tdo_hold  <= 1'b0;
      r_ir        <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_ir  <= cmd_ir;
        r_sr  <= cmd_data;
        r_cnt <= CNT_TOP;
        r_div <= '0;
        r_tck <= 1'b0;
      end else if (w_busy) begin
        if (w_half_end) begin
          r_div <= '0;
          r_tck <= ~r_tck;
        end else begin
          r_div <= r_div + 8'd1;
        end
        if (w_tck_rise) begin
          r_tdo_hold <= tdo;
        end
        if (w_step_end && (r_state == S_SDR)) begin
          r_sr <= {r_tdo_hold, r_sr[DR_WIDTH-1:1]};
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        if (w_step_end && (r_state == S_UDR)) begin
          r_rsp_data  <= r_sr;
          r_rsp_valid <= 1'b1;
        end
      end
    end
  end

  assign tck       = r_tck;
  assign ir_in     = r_ir;
  assign rsp_data  = r_rsp_data;
  assign rsp_valid = r_rsp_valid;

endmodule

// File: tb/tb_elc3_soc_jtag_scan_master.sv
// tb/tb_elc3_soc_jtag_scan_master.sv - bench for elc3_soc_jtag_scan_master
// Two DUTs: TCK_DIV=2 driven by a behavioural responder, TCK_DIV=1 in loopback.
module tb_elc3_soc_jtag_scan_master;

  localparam int DW = 38;

  logic          clk;
  logic          reset_n;
  int            checks;
  int            failures;

  logic          cmd_valid0, cmd_ready0, rsp_valid0, tck0, tdi0, tdo0;
  logic [1:0]    cmd_ir0, ir_in0;
  logic [DW-1:0] cmd_data0, rsp_data0;
  logic          vs_uir0, vs_cdr0, vs_sdr0, vs_udr0, rti0;

  logic          cmd_valid1, cmd_ready1, rsp_valid1, tck1, tdi1, tdo1;
  logic [1:0]    cmd_ir1, ir_in1;
  logic [DW-1:0] cmd_data1, rsp_data1;
  logic          vs_uir1, vs_cdr1, vs_sdr1, vs_udr1, rti1;

  assign tdo1 = tdi1;

  elc3_soc_jtag_scan_master #(.TCK_DIV(2), .DR_WIDTH(DW)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_ir(cmd_ir0), .cmd_data(cmd_data0),
    .rsp_valid(rsp_valid0), .rsp_data(rsp_data0),
    .tck(tck0), .tdi(tdi0), .tdo(tdo0), .ir_in(ir_in0),
    .vs_uir(vs_uir0), .vs_cdr(vs_cdr0), .vs_sdr(vs_sdr0), .vs_udr(vs_udr0),
    .jtag_state_rti(rti0)
  );

  elc3_soc_jtag_scan_master #(.TCK_DIV(1), .DR_WIDTH(DW)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_ir(cmd_ir1), .cmd_data(cmd_data1),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
    .tck(tck1), .tdi(tdi1), .tdo(tdo1), .ir_in(ir_in1),
    .vs_uir(vs_uir1), .vs_cdr(vs_cdr1), .vs_sdr(vs_sdr1), .vs_udr(vs_udr1),
    .jtag_state_rti(rti1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_ready"}, cmd_ready0, 1);
    check({tag, "_rti"}, rti0, 1);
    check({tag, "_rsp_valid"}, rsp_valid0, 0);
    check({tag, "_rsp_data"}, rsp_data0, 0);
    check({tag, "_tck"}, tck0, 0);
    check({tag, "_tdi"}, tdi0, 0);
    check({tag, "_ir_in"}, ir_in0, 0);
    check({tag, "_strobes"}, {vs_uir0, vs_cdr0, vs_sdr0, vs_udr0}, 0);
  endtask

  function automatic logic [DW-1:0] rand_dw();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[DW-1:0];
  endfunction

  // mode 0: responder presents pat[i] during SDR step i; 1: tdo = tdi; 2: tdo = 1
  // rst_at >= 0 aborts the scan with reset on that SDR cycle (4 cycles per step)
  task automatic run0(input string tag, input logic [1:0] ir, input logic [DW-1:0] data,
                      input int mode, input logic [DW-1:0] pat, input bit poke, input int rst_at);
    logic [DW-1:0] exp_rsp;
    int j, k, idx, n_uir, n_cdr, n_sdr, n_udr, n_hot, n_rdy, n_tdi, n_rv;
    exp_rsp = (mode == 1) ? data : (mode == 2) ? {DW{1'b1}} : pat;
    k = 0; n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_hot = 0; n_rdy = 0; n_tdi = 0;
    @(negedge clk);
    cmd_valid0 = 1'b1; cmd_ir0 = ir; cmd_data0 = data;
    check({tag, "_ready_idle"}, cmd_ready0, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid0 = 1'b0; cmd_ir0 = 2'($urandom()); cmd_data0 = rand_dw();
    check({tag, "_ir_in_after_accept"}, ir_in0, ir);
    j = 1;
    while (rsp_valid0 !== 1'b1 && j < 400) begin
      idx = k / 4;
      if (mode == 1) tdo0 = tdi0;
      else if (mode == 2) tdo0 = 1'b1;
      else tdo0 = (vs_sdr0 && idx < DW) ? pat[idx] : 1'b0;
      if (vs_uir0) n_uir++;
      if (vs_cdr0) n_cdr++;
      if (vs_sdr0) n_sdr++;
      if (vs_udr0) n_udr++;
      if ($countones({vs_uir0, vs_cdr0, vs_sdr0, vs_udr0}) != 1 || rti0) n_hot++;
      if (cmd_ready0) n_rdy++;
      if (tdi0) n_tdi++;
      if (poke && j == 60) begin
        cmd_valid0 = 1'b1; cmd_ir0 = 2'b11; cmd_data0 = rand_dw();
      end else if (poke && j == 61) begin
        cmd_valid0 = 1'b0;
      end
      if (rst_at >= 0 && vs_sdr0 && k == rst_at) begin
        reset_n = 1'b0;
        #1;
        check_reset0({tag, "_midrst"});
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n_rv = 0;
        repeat (200) begin
          @(negedge clk);
          if (rsp_valid0 || !cmd_ready0) n_rv++;
        end
        check({tag, "_no_rsp_after_reset"}, n_rv, 0);
        return;
      end
      if (vs_sdr0) k++;
      @(negedge clk);
      j++;
    end
    check({tag, "_latency"}, j, 165);
    check({tag, "_rsp_data"}, rsp_data0, exp_rsp);
    check({tag, "_uir_cycles"}, n_uir, 4);
    check({tag, "_cdr_cycles"}, n_cdr, 4);
    check({tag, "_sdr_cycles"}, n_sdr, 4 * DW);
    check({tag, "_udr_cycles"}, n_udr, 4);
    check({tag, "_onehot"}, n_hot, 0);
    check({tag, "_ready_busy"}, n_rdy, 0);
    check({tag, "_ready_rsp"}, cmd_ready0, 1);
    if (mode == 2) check({tag, "_tdi_zero"}, n_tdi, 0);
    @(negedge clk);
    check({tag, "_rsp_pulse"}, rsp_valid0, 0);
    check({tag, "_rsp_hold"}, rsp_data0, exp_rsp);
    check({tag, "_ir_in_hold"}, ir_in0, ir);
  endtask

  initial begin
    logic [1:0]    ir_a, ir_b;
    logic [DW-1:0] d_a, d_b;
    int            j, tck_err;
    logic          prev_tck;
    checks = 0; failures = 0;
    reset_n = 1'b0;
    cmd_valid0 = 1'b0; cmd_ir0 = 2'b00; cmd_data0 = '0; tdo0 = 1'b0;
    cmd_valid1 = 1'b0; cmd_ir1 = 2'b00; cmd_data1 = '0;
    repeat (3) @(negedge clk);
    check_reset0("reset");
    check("reset_dut1_ready", cmd_ready1, 1);
    check("reset_dut1_tck", tck1, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run0("loopback", 2'b01, 38'h2A_5A5A_5A5A, 1, '0, 1'b0, -1);
    run0("const_tdo", 2'b10, '0, 2, '0, 1'b0, -1);
    run0("busy_ignore", 2'b01, rand_dw(), 0, rand_dw(), 1'b1, -1);
    for (int i = 0; i < 3; i++) begin
      run0("random", 2'($urandom()), rand_dw(), 0, rand_dw(), 1'b0, -1);
    end
    run0("abort", 2'b10, rand_dw(), 0, rand_dw(), 1'b0, 40);
    check_reset0("after_abort");
    run0("fresh", 2'b11, rand_dw(), 0, rand_dw(), 1'b0, -1);

    // TCK_DIV=1, second command waiting with cmd_valid held high
    ir_a = 2'b10; ir_b = 2'b01; d_a = rand_dw(); d_b = rand_dw();
    @(negedge clk);
    cmd_valid1 = 1'b1; cmd_ir1 = ir_a; cmd_data1 = d_a;
    check("b2b_ready_first", cmd_ready1, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_ir1 = ir_b; cmd_data1 = d_b;
    check("b2b_ir_a", ir_in1, ir_a);
    tck_err = 0;
    for (int c = 0; c < 2; c++) begin
      j = 1;
      prev_tck = ~tck1;
      while (rsp_valid1 !== 1'b1 && j < 300) begin
        if (tck1 === prev_tck) tck_err++;
        prev_tck = tck1;
        @(negedge clk);
        j++;
      end
      check("b2b_latency", j, 83);
      check("b2b_rsp_data", rsp_data1, (c == 0) ? d_a : d_b);
      check("b2b_ready_in_rsp", cmd_ready1, 1);
      check("b2b_rti_in_rsp", rti1, 1);
      @(posedge clk);
      @(negedge clk);
      if (c == 0) begin
        check("b2b_second_accepted", cmd_ready1, 0);
        check("b2b_ir_b", ir_in1, ir_b);
      end else begin
        cmd_valid1 = 1'b0;
      end
    end
    check("b2b_tck_period", tck_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
